// File: rtl/conv2d_sequencer.sv
// conv2d_sequencer
// ----------------
// Sequencing controller for the combinational conv2d patch datapath. After a
// start pulse it walks every output pixel of one feature map in raster order.
// For each pixel it does four things in turn:
//   1. requests the matching input patch from the fetcher,
//   2. waits for the patch to be loaded,
//   3. captures the conv2d result vector,
//   4. offers the result downstream over a valid/ready handshake.
//
// Optional feature macro: CONV2D_SEQ_RELU_EN.
//   Defined:   any result lane with its sign bit set is captured as zero.
//   Undefined: lanes are captured unmodified.
//   Latency is the same in both builds.
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset
//   start            in   launch one feature-map pass (honoured only when idle)
//   busy             out  pass in progress (cycle after start .. DONE state)
//   done             out  one-cycle pulse after the final pixel is accepted
//   patch_req_valid  out  patch request valid
//   patch_req_ready  in   fetcher accepts the request
//   patch_y/patch_x  out  signed top-left input coordinate of the patch
//   patch_done       in   fetcher pulse: patch register loaded
//   conv_result      in   conv2d output vector, OUT_CH lanes of ACC_WIDTH bits
//   out_valid        out  captured pixel valid
//   out_ready        in   downstream accepts the pixel
//   out_data         out  captured result vector, lane oc at [ACC_WIDTH*oc +: ACC_WIDTH]
//   out_y/out_x      out  unsigned output pixel coordinate
//   out_last         out  final pixel of the pass (qualified by out_valid)

module conv2d_sequencer #(
    parameter int IN_H      = 8,
    parameter int IN_W      = 8,
    parameter int KH        = 3,
    parameter int KW        = 3,
    parameter int STRIDE    = 1,
    parameter int PAD       = 1,
    parameter int OUT_CH    = 1,
    parameter int ACC_WIDTH = 32,
    parameter int COORD_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        patch_req_valid,
    input  logic                        patch_req_ready,
    output logic [COORD_W-1:0]          patch_y,
    output logic [COORD_W-1:0]          patch_x,
    input  logic                        patch_done,
    input  logic [ACC_WIDTH*OUT_CH-1:0] conv_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH*OUT_CH-1:0] out_data,
    output logic [COORD_W-1:0]          out_y,
    output logic [COORD_W-1:0]          out_x,
    output logic                        out_last
);

    localparam int OUT_H = (IN_H + 2*PAD - KH) / STRIDE + 1;
    localparam int OUT_W = (IN_W + 2*PAD - KW) / STRIDE + 1;

    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(OUT_H - 1);
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(OUT_W - 1);
    localparam logic [COORD_W-1:0] STEP   = COORD_W'(STRIDE);
    localparam logic [COORD_W-1:0] ORIGIN = COORD_W'(-PAD);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [COORD_W-1:0]            oy_q, oy_d;
    logic [COORD_W-1:0]            ox_q, ox_d;
    logic [COORD_W-1:0]            py_q, py_d;
    logic [COORD_W-1:0]            px_q, px_d;
    logic [ACC_WIDTH*OUT_CH-1:0]   data_q, data_d;
    logic [ACC_WIDTH*OUT_CH-1:0]   capture_val;
    logic                          is_last;

    // Per-lane capture value. With the ReLU build a negative lane is forced to
    // zero before it reaches the holding register.
    for (genvar gi = 0; gi < OUT_CH; gi++) begin : g_lane
        logic [ACC_WIDTH-1:0] lane_in;
        assign lane_in = conv_result[ACC_WIDTH*gi +: ACC_WIDTH];
`ifdef CONV2D_SEQ_RELU_EN
        assign capture_val[ACC_WIDTH*gi +: ACC_WIDTH] =
            lane_in[ACC_WIDTH-1] ? '0 : lane_in;
`else
        assign capture_val[ACC_WIDTH*gi +: ACC_WIDTH] = lane_in;
`endif
    end

    assign is_last = (oy_q == LAST_Y) && (ox_q == LAST_X);

    always_comb begin
        state_d = state_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        py_d    = py_q;
        px_d    = px_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    oy_d    = '0;
                    ox_d    = '0;
                    py_d    = ORIGIN;
                    px_d    = ORIGIN;
                end
            end
            S_REQ: begin
                if (patch_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (patch_done) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // conv2d has had the whole previous cycle to settle.
                data_d  = capture_val;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        // Patch coordinates track the counters incrementally,
                        // so no multiplier is needed.
                        if (ox_q == LAST_X) begin
                            ox_d = '0;
                            oy_d = oy_q + ONE;
                            px_d = ORIGIN;
                            py_d = py_q + STEP;
                        end else begin
                            ox_d = ox_q + ONE;
                            px_d = px_q + STEP;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            oy_q    <= '0;
            ox_q    <= '0;
            py_q    <= '0;
            px_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            py_q    <= py_d;
            px_q    <= px_d;
            data_q  <= data_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign patch_req_valid = (state_q == S_REQ);
    assign out_valid       = (state_q == S_OUT);
    assign out_last        = (state_q == S_OUT) && is_last;
    assign patch_y         = py_q;
    assign patch_x         = px_q;
    assign out_y           = oy_q;
    assign out_x           = ox_q;
    assign out_data        = data_q;

endmodule

// File: tb/tb_conv2d_sequencer.sv
// Testbench for conv2d_sequencer.
// Instance A: 4x4 input, 3x3 kernel, stride 1, pad 1, two result lanes.
// Instance B: 5x5 input, 3x3 kernel, stride 2, pad 0, one result lane.
// The reference is a raster list of expected pixels built from the output
// geometry formula. Result lanes are random, and ReLU is applied as a signed
// comparison in the ReLU build.

module tb_conv2d_sequencer;

    localparam int A_IN = 4, A_K = 3, A_S = 1, A_P = 1, A_CH = 2;
    localparam int A_OH = (A_IN + 2*A_P - A_K) / A_S + 1;
    localparam int A_N  = A_OH * A_OH;
    localparam int B_IN = 5, B_K = 3, B_S = 2, B_P = 0;
    localparam int B_OH = (B_IN + 2*B_P - B_K) / B_S + 1;

    typedef struct {
        logic [7:0] py;
        logic [7:0] px;
        logic [7:0] oy;
        logic [7:0] ox;
        logic       last;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    pix_t        exp_a[$];
    pix_t        exp_b[$];

    // Instance A signals
    logic        start_a, busy_a, done_a, req_valid_a, req_ready_a, pdone_a;
    logic [7:0]  py_a, px_a, oy_a, ox_a;
    logic [63:0] res_a, data_a;
    logic        out_valid_a, out_ready_a, last_a;

    // Instance B signals
    logic        start_b, busy_b, done_b, req_valid_b, req_ready_b, pdone_b;
    logic [7:0]  py_b, px_b, oy_b, ox_b;
    logic [31:0] res_b, data_b;
    logic        out_valid_b, out_ready_b, last_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d_sequencer #(
        .IN_H(A_IN), .IN_W(A_IN), .KH(A_K), .KW(A_K), .STRIDE(A_S), .PAD(A_P),
        .OUT_CH(A_CH), .ACC_WIDTH(32), .COORD_W(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .patch_req_valid(req_valid_a), .patch_req_ready(req_ready_a),
        .patch_y(py_a), .patch_x(px_a), .patch_done(pdone_a),
        .conv_result(res_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(data_a), .out_y(oy_a), .out_x(ox_a), .out_last(last_a)
    );

    conv2d_sequencer #(
        .IN_H(B_IN), .IN_W(B_IN), .KH(B_K), .KW(B_K), .STRIDE(B_S), .PAD(B_P),
        .OUT_CH(1), .ACC_WIDTH(32), .COORD_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .patch_req_valid(req_valid_b), .patch_req_ready(req_ready_b),
        .patch_y(py_b), .patch_x(px_b), .patch_done(pdone_b),
        .conv_result(res_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(data_b), .out_y(oy_b), .out_x(ox_b), .out_last(last_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] relu_ref(input logic [31:0] v);
`ifdef CONV2D_SEQ_RELU_EN
        return ($signed(v) < 0) ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    // Raster-order list of expected pixels for an oh x oh output map.
    function automatic void build_model(input int oh, input int s, input int p,
                                        output pix_t q[$]);
        pix_t e;
        q = {};
        for (int y = 0; y < oh; y++) begin
            for (int x = 0; x < oh; x++) begin
                e.py   = 8'(y*s - p);
                e.px   = 8'(x*s - p);
                e.oy   = 8'(y);
                e.ox   = 8'(x);
                e.last = (y == oh-1) && (x == oh-1);
                q.push_back(e);
            end
        end
    endfunction

    // Serves one pixel on instance A. On entry the DUT must be in its request
    // cycle. With abort set, the task returns in the WAIT state.
    task automatic serve_pixel(input int idx, input int req_stall, input int done_delay,
                               input int out_stall, input logic [31:0] l0,
                               input logic [31:0] l1, input bit glitch, input bit abort);
        pix_t        e;
        logic [63:0] exp_data;
        e        = exp_a[idx];
        exp_data = {relu_ref(l1), relu_ref(l0)};
        chk("req_valid", {63'd0, req_valid_a}, 64'd1);
        chk("busy", {63'd0, busy_a}, 64'd1);
        chk("patch_y", {56'd0, py_a}, {56'd0, e.py});
        chk("patch_x", {56'd0, px_a}, {56'd0, e.px});
        for (int i = 0; i < req_stall; i++) begin
            req_ready_a = 1'b0;
            if (glitch) begin pdone_a = 1'b1; start_a = 1'b1; end
            tick;
            pdone_a = 1'b0; start_a = 1'b0;
            chk("req_hold", {63'd0, req_valid_a}, 64'd1);
            chk("patch_y_hold", {56'd0, py_a}, {56'd0, e.py});
            chk("patch_x_hold", {56'd0, px_a}, {56'd0, e.px});
        end
        req_ready_a = 1'b1;
        tick;
        req_ready_a = 1'b0;
        chk("req_drop", {63'd0, req_valid_a}, 64'd0);
        if (abort) return;
        for (int i = 0; i < done_delay; i++) begin
            tick;
            chk("wait_no_out", {63'd0, out_valid_a}, 64'd0);
        end
        res_a   = {l1, l0};
        pdone_a = 1'b1;
        tick;
        pdone_a = 1'b0;
        tick;
        // Changing the input after capture must not disturb the held data.
        res_a = {$urandom, $urandom};
        chk("out_valid", {63'd0, out_valid_a}, 64'd1);
        chk("out_data", data_a, exp_data);
        chk("out_y", {56'd0, oy_a}, {56'd0, e.oy});
        chk("out_x", {56'd0, ox_a}, {56'd0, e.ox});
        chk("out_last", {63'd0, last_a}, {63'd0, e.last});
        for (int i = 0; i < out_stall; i++) begin
            out_ready_a = 1'b0;
            if (glitch) begin pdone_a = 1'b1; start_a = 1'b1; end
            tick;
            pdone_a = 1'b0; start_a = 1'b0;
            chk("out_hold", {63'd0, out_valid_a}, 64'd1);
            chk("out_data_hold", data_a, exp_data);
            chk("out_y_hold", {56'd0, oy_a}, {56'd0, e.oy});
            chk("out_x_hold", {56'd0, ox_a}, {56'd0, e.ox});
        end
        out_ready_a = 1'b1;
        tick;
        out_ready_a = 1'b0;
        $display("pixel %0d oy=%0d ox=%0d patch=(%0d,%0d) data=%h last=%0d",
                 idx, e.oy, e.ox, $signed(e.py), $signed(e.px), exp_data, e.last);
    endtask

    task automatic do_start_a;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
    endtask

    // One full pass on instance A. A nonnegative abort_pix applies reset while
    // that pixel is in WAIT.
    task automatic run_pass(input bit zero_wait, input int abort_pix);
        int          c_first;
        int          rs, dd, os;
        bit          gl;
        logic [31:0] l0, l1;
        do_start_a;
        c_first = cyc;
        for (int idx = 0; idx < A_N; idx++) begin
            rs = zero_wait ? 0 : int'($urandom_range(0, 2));
            dd = zero_wait ? 0 : int'($urandom_range(0, 2));
            os = zero_wait ? 0 : int'($urandom_range(0, 2));
            gl = 1'b0;
            l0 = $urandom;
            l1 = $urandom;
            if (!zero_wait && idx == 2) begin rs = 3; os = 5; end
            if (!zero_wait && (idx == 4 || idx == 5)) begin rs = 2; os = 2; gl = 1'b1; end
            if (idx == 1) begin l0 = 32'hFFFF_FFFB; l1 = 32'd7; end
            if (idx == abort_pix) begin
                serve_pixel(idx, rs, dd, os, l0, l1, gl, 1'b1);
                rst_n = 1'b0;
                tick;
                rst_n = 1'b1;
                chk("rst_busy", {63'd0, busy_a}, 64'd0);
                chk("rst_done", {63'd0, done_a}, 64'd0);
                chk("rst_req", {63'd0, req_valid_a}, 64'd0);
                chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
                chk("rst_last", {63'd0, last_a}, 64'd0);
                chk("rst_data", data_a, 64'd0);
                chk("rst_coords", {32'd0, py_a, px_a, oy_a, ox_a}, 64'd0);
                for (int i = 0; i < 4; i++) begin
                    pdone_a = 1'b1;
                    tick;
                    pdone_a = 1'b0;
                    chk("rst_no_done", {62'd0, done_a, busy_a}, 64'd0);
                end
                $display("pass aborted by reset at pixel %0d", idx);
                return;
            end
            serve_pixel(idx, rs, dd, os, l0, l1, gl, 1'b0);
        end
        chk("done", {63'd0, done_a}, 64'd1);
        chk("done_busy", {63'd0, busy_a}, 64'd1);
        chk("done_no_out", {63'd0, out_valid_a}, 64'd0);
        if (zero_wait) chk("pass_cycles", 64'(cyc - c_first + 1), 64'(4*A_N + 1));
        // start coinciding with done must be ignored.
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("idle_done", {63'd0, done_a}, 64'd0);
        chk("idle_busy", {63'd0, busy_a}, 64'd0);
        chk("idle_req", {63'd0, req_valid_a}, 64'd0);
        $display("pass complete pixels=%0d", A_N);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; req_ready_a = 1'b0; pdone_a = 1'b0; out_ready_a = 1'b0; res_a = '0;
        start_b = 1'b0; req_ready_b = 1'b1; pdone_b = 1'b0; out_ready_b = 1'b1;
        res_b = 32'h0000_1234;
        build_model(A_OH, A_S, A_P, exp_a);
        build_model(B_OH, B_S, B_P, exp_b);
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("reset_ctrl_a", {59'd0, busy_a, done_a, req_valid_a, out_valid_a, last_a}, 64'd0);
        chk("reset_data_a", data_a, 64'd0);
        chk("reset_coords_a", {32'd0, py_a, px_a, oy_a, ox_a}, 64'd0);
        chk("reset_ctrl_b", {59'd0, busy_b, done_b, req_valid_b, out_valid_b, last_b}, 64'd0);

        // Instance B: stride 2, no padding, zero-wait responders.
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        for (int i = 0; i < B_OH*B_OH; i++) begin
            chk("b_req_valid", {63'd0, req_valid_b}, 64'd1);
            chk("b_patch", {48'd0, py_b, px_b}, {48'd0, exp_b[i].py, exp_b[i].px});
            tick;
            pdone_b = 1'b1;
            tick;
            pdone_b = 1'b0;
            tick;
            chk("b_out_valid", {63'd0, out_valid_b}, 64'd1);
            chk("b_out_xy", {48'd0, oy_b, ox_b}, {48'd0, exp_b[i].oy, exp_b[i].ox});
            chk("b_out_last", {63'd0, last_b}, {63'd0, exp_b[i].last});
            chk("b_out_data", {32'd0, data_b}, {32'd0, relu_ref(res_b)});
            $display("b pixel %0d out=(%0d,%0d) patch=(%0d,%0d)",
                     i, oy_b, ox_b, py_b, px_b);
            tick;
        end
        chk("b_done", {63'd0, done_b}, 64'd1);

        // Instance A: zero-wait pass, then a randomized pass that starts in
        // the cycle right after done.
        run_pass(1'b1, -1);
        run_pass(1'b0, -1);
        // Reset while pixel 3 is in WAIT, then a clean zero-wait restart.
        run_pass(1'b0, 3);
        run_pass(1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2d_sequencer.md
# conv2d_sequencer

Sequencing controller for the combinational `conv2d` patch datapath. On `start` it walks every output pixel position of one feature map in raster order and requests the matching input patch from an external patch fetcher. After each patch is loaded, it captures the `conv2d` output vector into a holding register and presents it downstream over a valid/ready handshake. It sits between the line-buffer/patch fetcher, the `conv2d` array and the output writer of a YOLO conv layer.

## Interface
- `IN_H`, 8: input feature-map height.
- `IN_W`, 8: input feature-map width.
- `KH`, 3: kernel height.
- `KW`, 3: kernel width.
- `STRIDE`, 1: stride, used in both dimensions (≥1).
- `PAD`, 1: zero-padding on every border (≥0).
- `OUT_CH`, 1: output channels in the `conv2d` result vector.
- `ACC_WIDTH`, 32: width of each result lane.
- `COORD_W`, 8: width of the signed coordinate ports.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  launches one full feature-map pass; only accepted in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is exited.
- `done`  out  1  one-cycle pulse after the last pixel is accepted downstream.
- `patch_req_valid`  out  1  patch request valid.
- `patch_req_ready`  in  1  fetcher accepts the request.
- `patch_y`  out  COORD_W  signed top-left input row of the patch: `oy*STRIDE-PAD`.
- `patch_x`  out  COORD_W  signed top-left input column: `ox*STRIDE-PAD`.
- `patch_done`  in  1  pulse from the fetcher: the patch register feeding `conv2d` is loaded.
- `conv_result`  in  ACC_WIDTH*OUT_CH  `conv2d` output vector (`out_pix_flat`).
- `out_valid`  out  1  captured pixel valid.
- `out_ready`  in  1  downstream accepts the pixel.
- `out_data`  out  ACC_WIDTH*OUT_CH  captured result; lane `oc` is at bits `[ACC_WIDTH*oc +: ACC_WIDTH]`.
- `out_y`, `out_x`  out  COORD_W each  unsigned output pixel coordinates.
- `out_last`  out  1  high together with `out_valid` for the final pixel.

## Operation
- `OUT_H = (IN_H+2*PAD-KH)/STRIDE+1` and `OUT_W = (IN_W+2*PAD-KW)/STRIDE+1`, using integer division, evaluated at elaboration.
- Counters `oy` and `ox` run in raster order: `ox` increments first. At `OUT_W-1` it wraps to 0 and `oy` increments. The pixel with `oy=OUT_H-1` and `ox=OUT_W-1` is last.
- States:
  - IDLE: `start` goes to REQ and clears `oy`/`ox` to 0.
  - REQ: when `patch_req_valid && patch_req_ready`, go to WAIT.
  - WAIT: when `patch_done`, go to CAPTURE.
  - CAPTURE: register `conv_result` into `out_data`, then go to OUT.
  - OUT: on `out_valid && out_ready`, go to DONE if this is the last pixel; otherwise advance the counters and go to REQ.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Padding borders are signalled only by negative or out-of-range `patch_y`/`patch_x`. Zero fill is the fetcher's job.
- Coordinates are computed in COORD_W-bit signed arithmetic. Configurations must keep `OUT_H*STRIDE` within the signed range.
- `patch_y`, `patch_x`, `out_y` and `out_x` are held stable while their respective valid signal is high, until the handshake completes.
- Ignored inputs:
  - `start` in any state other than IDLE.
  - `patch_done` in any state other than WAIT.
  - `out_ready` in any state other than OUT.

## Timing
- Reset values: state IDLE; `busy`, `done`, `patch_req_valid`, `out_valid` and `out_last` all 0; `out_data`, `patch_*` and `out_*` coordinates all 0.
- Reset asserted in any state takes effect on the next edge. Any in-flight pixel is discarded and no `done` is produced.
- `start` sampled in cycle t gives `patch_req_valid=1` and `busy=1` in cycle t+1.
- `patch_done` sampled in WAIT at cycle t means `conv_result` is sampled at the end of cycle t+1 (CAPTURE). This gives the combinational `conv2d` one full cycle to settle. `out_valid` is high from cycle t+2.
- Minimum pixel period is 4 cycles (REQ, WAIT, CAPTURE, OUT) with `patch_req_ready`, `patch_done` and `out_ready` all responding immediately.
- A full pass with no stalls takes `4*OUT_H*OUT_W+1` cycles from the first REQ cycle through DONE.
- `done` is high exactly in the cycle after the last OUT handshake. `busy` drops in the cycle after `done`.
- `start` presented in the same cycle as `done` is ignored. `start` in the cycle after `done` (IDLE) is accepted.

## Configuration
- `CONV2D_SEQ_RELU_EN`:
  - Defined: at CAPTURE, each ACC_WIDTH lane of `conv_result` with the sign bit set is replaced by 0 before it is registered.
  - Undefined: lanes are registered unmodified.
- The macro has no effect on latency.

## Test plan
- Geometry 4×4 input, 3×3 kernel, STRIDE=1, PAD=1, zero-wait responders: expect 16 pixels.
  - First `patch_y`,`patch_x` = (−1,−1); last = (2,2).
  - `out_last` only on (3,3).
  - `done` arrives 65 cycles after the first REQ.
- Geometry 5×5 input, STRIDE=2, PAD=0: expect requests (0,0), (0,2), (2,0), (2,2) and `out_y`,`out_x` = (0,0), (0,1), (1,0), (1,1).
- Backpressure: hold `out_ready=0` for 5 cycles and `patch_req_ready=0` for 3 cycles on pixel 2.
  - `out_data`, coordinates and `patch_*` stay stable.
  - No pixel is dropped or duplicated.
- Result lane = 0xFFFFFFFB (−5), lane 1 = 7, with OUT_CH=2: `out_data` lane 0 is 0 with `CONV2D_SEQ_RELU_EN` and 0xFFFFFFFB without it; lane 1 is 7 in both builds.
- Pulse `start` while `busy` and pulse `patch_done` during REQ/OUT: no state change and pixel count unchanged.
- Deassert `rst_n` in WAIT on pixel 3: all outputs take their reset values on the next edge, and no `done` is produced. A following `start` restarts at (−1,−1).
